// File: rtl/ghost_sprite_renderer_if.sv
// Position-request channel for the ghost sprite renderer.
// The master offers a new sprite tile position; the renderer (slave)
// holds it until the next frame boundary and then makes it live.
interface ghost_sprite_renderer_if;
  logic [4:0] pos_x;
  logic [4:0] pos_y;
  logic       pos_valid;
  logic       pos_ready;

  modport master (
    output pos_x,
    output pos_y,
    output pos_valid,
    input  pos_ready
  );

  modport slave (
    input  pos_x,
    input  pos_y,
    input  pos_valid,
    output pos_ready
  );
endinterface

// File: rtl/ghost_sprite_renderer.sv
// Two-stage tile-grid sprite renderer.
// Stage 1 turns the beam position into a tile coordinate. Stage 2 looks the
// tile up in a two-frame ghost ROM and composites it over the background.
// Position requests and the animation frame only change at frame boundaries,
// which fall in vertical blanking, so a frame never shows a torn sprite.
module ghost_sprite_renderer #(
  parameter int                 HPIXELS     = 640,
  parameter int                 VPIXELS     = 480,
  parameter int                 TILE        = 20,
  parameter int                 SPR_W       = 14,
  parameter int                 SPR_H       = 14,
  parameter int                 COLOR_W     = 8,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 8'h00,
  parameter logic [COLOR_W-1:0] BG_COLOR    = 8'h03,
  parameter int                 ANIM_DIV    = 15,
  parameter int                 INIT_X      = 9,
  parameter int                 INIT_Y      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             hc,
  input  logic [9:0]             vc,
  ghost_sprite_renderer_if.slave pos,
  output logic [9:0]             px_address,
  output logic [COLOR_W-1:0]     px_color,
  output logic                   px_active,
  output logic                   frame_tick
);

  localparam int GRID_W  = HPIXELS / TILE;
  localparam int GRID_H  = VPIXELS / TILE;
  localparam int MAX_X   = GRID_W - SPR_W;
  localparam int MAX_Y   = GRID_H - SPR_H;
  localparam int CNT_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  // The ghost artwork is drawn on a fixed 14x14 tile canvas.
  localparam int ART_DIM = 14;

  localparam logic [COLOR_W-1:0] COL_BODY  = COLOR_W'(8'he0);
  localparam logic [COLOR_W-1:0] COL_WHITE = COLOR_W'(8'hff);
  localparam logic [COLOR_W-1:0] COL_PUPIL = COLOR_W'(8'h02);

  // Ghost artwork: bit n of each mask is tile column n. Frame 1 differs only
  // in the skirt rows, where the points are shifted one tile to the right.
  function automatic logic [COLOR_W-1:0] romRead(input logic sel,
                                                 input logic [4:0] row,
                                                 input logic [4:0] col);
    logic [13:0]        body;
    logic [13:0]        white;
    logic [13:0]        pupil;
    logic [3:0]         ci;
    logic [COLOR_W-1:0] val;
    body  = '0;
    white = '0;
    pupil = '0;
    ci    = col[3:0];
    val   = TRANSPARENT;
    case (row)
      5'd0:  body = 14'b00_0001_1110_0000;
      5'd1:  body = 14'b00_0111_1111_1000;
      5'd2:  body = 14'b00_1111_1111_1100;
      5'd3, 5'd5: begin
        body  = 14'b01_1111_1111_1110;
        white = 14'b00_0011_0001_1000;
      end
      5'd4: begin
        body  = 14'b01_1111_1111_1110;
        white = 14'b00_0001_0000_1000;
        pupil = 14'b00_0010_0001_0000;
      end
      5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11:
             body = 14'b11_1111_1111_1111;
      5'd12: body = sel ? 14'b10_1110_1110_1110 : 14'b11_0111_0111_0111;
      5'd13: body = sel ? 14'b10_0110_0110_0110 : 14'b11_0011_0011_0011;
      default: body = '0;
    endcase
    if (col < 5'(ART_DIM)) begin
      if (pupil[ci])      val = COL_PUPIL;
      else if (white[ci]) val = COL_WHITE;
      else if (body[ci])  val = COL_BODY;
    end
    return val;
  endfunction

  logic [4:0]         tile_x_d, tile_x_q;
  logic [4:0]         tile_y_d, tile_y_q;
  logic               vis_d, vis_q;
  logic               fb;
  logic [4:0]         rel_x, rel_y;
  logic               in_spr;
  logic [COLOR_W-1:0] rom_val;
  logic [COLOR_W-1:0] color_d;
  logic [9:0]         addr_d;
  logic               accept;
  logic [4:0]         clamp_x, clamp_y;
  logic               pend_full_d, pend_full_q;
  logic [4:0]         pend_x_d, pend_x_q;
  logic [4:0]         pend_y_d, pend_y_q;
  logic [4:0]         live_x_d, live_x_q;
  logic [4:0]         live_y_d, live_y_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               anim_d, anim_q;
  logic               tick_q;
  logic [COLOR_W-1:0] color_q;
  logic [9:0]         addr_q;
  logic               active_q;

  // Stage 1 decode: visibility, tile coordinate and the frame-boundary event.
  always_comb begin
    vis_d    = (hc < 10'(HPIXELS)) && (vc < 10'(VPIXELS));
    tile_x_d = 5'(hc / 10'(TILE));
    tile_y_d = 5'(vc / 10'(TILE));
    fb       = (hc == 10'd0) && (vc == 10'(VPIXELS));
  end

  // Stage 2 lookup: negative offsets wrap to large values and fail the range test.
  always_comb begin
    rel_x   = tile_x_q - live_x_q;
    rel_y   = tile_y_q - live_y_q;
    in_spr  = (rel_x < 5'(SPR_W)) && (rel_y < 5'(SPR_H));
    rom_val = romRead(anim_q, rel_y, rel_x);
    color_d = '0;
    addr_d  = '0;
    if (vis_q) begin
      color_d = (in_spr && (rom_val != TRANSPARENT)) ? rom_val : BG_COLOR;
      addr_d  = 10'(tile_y_q) * 10'(GRID_W) + 10'(tile_x_q);
    end
  end

  assign pos.pos_ready = !pend_full_q && !rst;

  // Pending request, live position and animation bookkeeping around frame boundaries.
  always_comb begin
    accept      = pos.pos_valid && pos.pos_ready;
    clamp_x     = (pos.pos_x > 5'(MAX_X)) ? 5'(MAX_X) : pos.pos_x;
    clamp_y     = (pos.pos_y > 5'(MAX_Y)) ? 5'(MAX_Y) : pos.pos_y;
    pend_full_d = pend_full_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    live_x_d    = live_x_q;
    live_y_d    = live_y_q;
    cnt_d       = cnt_q;
    anim_d      = anim_q;
    if (fb) begin
      if (pend_full_q) begin
        live_x_d    = pend_x_q;
        live_y_d    = pend_y_q;
        pend_full_d = 1'b0;
      end
      if (cnt_q == CNT_W'(ANIM_DIV - 1)) begin
        cnt_d  = '0;
        anim_d = !anim_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (accept) begin
      pend_x_d    = clamp_x;
      pend_y_d    = clamp_y;
      pend_full_d = 1'b1;
    end
  end

  // All state registers; reset flushes the pipeline and drops any pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_x_q    <= '0;
      tile_y_q    <= '0;
      vis_q       <= 1'b0;
      color_q     <= '0;
      addr_q      <= '0;
      active_q    <= 1'b0;
      tick_q      <= 1'b0;
      pend_full_q <= 1'b0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      live_x_q    <= 5'(INIT_X);
      live_y_q    <= 5'(INIT_Y);
      cnt_q       <= '0;
      anim_q      <= 1'b0;
    end else begin
      tile_x_q    <= tile_x_d;
      tile_y_q    <= tile_y_d;
      vis_q       <= vis_d;
      color_q     <= color_d;
      addr_q      <= addr_d;
      active_q    <= vis_q;
      tick_q      <= fb;
      pend_full_q <= pend_full_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      live_x_q    <= live_x_d;
      live_y_q    <= live_y_d;
      cnt_q       <= cnt_d;
      anim_q      <= anim_d;
    end
  end

  assign px_color   = color_q;
  assign px_address = addr_q;
  assign px_active  = active_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_ghost_sprite_renderer.sv
// Self-checking bench for ghost_sprite_renderer: a pixel-level reference
// model drawn from ASCII artwork, checked every cycle, plus directed scenes.
module tb_ghost_sprite_renderer;
  logic       clk;
  logic       rst;
  logic [9:0] hc;
  logic [9:0] vc;
  logic [9:0] px_address;
  logic [7:0] px_color;
  logic       px_active;
  logic       frame_tick;
  bit         checkEn;
  int         nCompared;
  int         nMismatch;

  ghost_sprite_renderer_if posIf ();

  ghost_sprite_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .hc         (hc),
    .vc         (vc),
    .pos        (posIf),
    .px_address (px_address),
    .px_color   (px_color),
    .px_active  (px_active),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ghost artwork, column 0 on the left; R body, W eye white, B pupil.
  string art0 [14] = '{
    ".....RRRR.....", "...RRRRRRRR...", "..RRRRRRRRRR..",
    ".RRWWRRRWWRRR.", ".RRWBRRRWBRRR.", ".RRWWRRRWWRRR.",
    "RRRRRRRRRRRRRR", "RRRRRRRRRRRRRR", "RRRRRRRRRRRRRR",
    "RRRRRRRRRRRRRR", "RRRRRRRRRRRRRR", "RRRRRRRRRRRRRR",
    "RRR.RRR.RRR.RR", "RR..RR..RR..RR"};
  string art1 [14] = '{
    ".....RRRR.....", "...RRRRRRRR...", "..RRRRRRRRRR..",
    ".RRWWRRRWWRRR.", ".RRWBRRRWBRRR.", ".RRWWRRRWWRRR.",
    "RRRRRRRRRRRRRR", "RRRRRRRRRRRRRR", "RRRRRRRRRRRRRR",
    "RRRRRRRRRRRRRR", "RRRRRRRRRRRRRR", "RRRRRRRRRRRRRR",
    ".RRR.RRR.RRR.R", ".RR..RR..RR..R"};

  // Reference model state.
  int         mLiveX = 9, mLiveY = 5, mPendX = 0, mPendY = 0, mFrames = 0;
  bit         mPend = 0, mAnim = 0;
  logic [7:0] s1Color = 0, mColor = 0;
  logic [9:0] s1Addr = 0, mAddr = 0;
  bit         s1Active = 0, mActive = 0, mTick = 0;

  function automatic logic [7:0] artColor(input bit frame, input int r, input int c);
    string row;
    byte   ch;
    row = frame ? art1[r] : art0[r];
    ch  = row[c];
    case (ch)
      "R":     return 8'he0;
      "W":     return 8'hff;
      "B":     return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

  // Reference model: what each sampled beam position must look like on screen.
  always @(posedge clk) begin
    bit fbNow, accNow;
    int tx, ty, rx, ry;
    logic [7:0] art;
    if (rst) begin
      mColor = 0; mAddr = 0; mActive = 0; mTick = 0;
      s1Color = 0; s1Addr = 0; s1Active = 0;
      mPend = 0; mLiveX = 9; mLiveY = 5; mFrames = 0; mAnim = 0;
    end else begin
      fbNow   = (hc == 0) && (vc == 480);
      accNow  = posIf.pos_valid && !mPend;
      mColor  = s1Color;
      mAddr   = s1Addr;
      mActive = s1Active;
      mTick   = fbNow;
      if (fbNow) begin
        if (mPend) begin
          mLiveX = mPendX;
          mLiveY = mPendY;
          mPend  = 0;
        end
        mFrames++;
        if (mFrames == 15) begin
          mFrames = 0;
          mAnim   = !mAnim;
        end
      end
      if (accNow) begin
        mPendX = (posIf.pos_x > 18) ? 18 : int'(posIf.pos_x);
        mPendY = (posIf.pos_y > 10) ? 10 : int'(posIf.pos_y);
        mPend  = 1;
      end
      if (hc < 640 && vc < 480) begin
        tx = hc / 20;
        ty = vc / 20;
        rx = tx - mLiveX;
        ry = ty - mLiveY;
        s1Color = 8'h03;
        if (rx >= 0 && rx < 14 && ry >= 0 && ry < 14) begin
          art = artColor(mAnim, ry, rx);
          if (art != 8'h00) s1Color = art;
        end
        s1Addr   = 10'(ty * 32 + tx);
        s1Active = 1;
      end else begin
        s1Color = 0; s1Addr = 0; s1Active = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one set of inputs just after a rising edge; sampled on the next edge.
  task automatic applyStimulus(input int h, input int v, input bit valid,
                               input int x, input int y, input bit r);
    @(posedge clk);
    #2;
    hc              = 10'(h);
    vc              = 10'(v);
    posIf.pos_valid = valid;
    posIf.pos_x     = 5'(x);
    posIf.pos_y     = 5'(y);
    rst             = r;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkPixel(input string name, input logic [7:0] color,
                            input logic [9:0] addr, input bit active);
    checkOutput({name, " color"}, 32'(px_color), 32'(color));
    checkOutput({name, " address"}, 32'(px_address), 32'(addr));
    checkOutput({name, " active"}, 32'(px_active), 32'(active));
  endtask

  // Every-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model px_color", 32'(px_color), 32'(mColor));
      checkOutput("model px_address", 32'(px_address), 32'(mAddr));
      checkOutput("model px_active", 32'(px_active), 32'(mActive));
      checkOutput("model frame_tick", 32'(frame_tick), 32'(mTick));
      checkOutput("model pos_ready", 32'(posIf.pos_ready), 32'(!mPend && !rst));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    nCompared = 0;
    nMismatch = 0;
    checkEn   = 0;
    rst = 1; hc = 0; vc = 0;
    posIf.pos_valid = 0; posIf.pos_x = 0; posIf.pos_y = 0;
    @(posedge clk);
    #2;
    checkEn = 1;
    @(negedge clk);
    checkPixel("reset", 8'h00, 10'd0, 1'b0);
    checkOutput("reset pos_ready", 32'(posIf.pos_ready), 32'd0);
    checkOutput("reset frame_tick", 32'(frame_tick), 32'd0);

    // Background at the top-left corner.
    applyStimulus(0, 0, 0, 0, 0, 0);
    settle(2);
    checkPixel("corner", 8'h03, 10'd0, 1'b1);

    // Eye white of the ghost at its default position.
    applyStimulus(260, 160, 0, 0, 0, 0);
    settle(2);
    checkPixel("eye white", 8'hff, 10'd269, 1'b1);

    // Transparent sprite corner shows background.
    applyStimulus(180, 100, 0, 0, 0, 0);
    settle(2);
    checkPixel("transparent corner", 8'h03, 10'd169, 1'b1);

    // Off-screen positions.
    applyStimulus(640, 100, 0, 0, 0, 0);
    settle(2);
    checkPixel("right blank", 8'h00, 10'd0, 1'b0);
    applyStimulus(100, 480, 0, 0, 0, 0);
    settle(2);
    checkPixel("bottom blank", 8'h00, 10'd0, 1'b0);

    // Move request, clamped, plus a second request that must be ignored.
    applyStimulus(700, 100, 1, 31, 31, 0);
    settle(1);
    checkOutput("ready after accept", 32'(posIf.pos_ready), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(700, 100, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("ready while pending", 32'(posIf.pos_ready), 32'd0);
    applyStimulus(700, 100, 0, 0, 0, 0);
    applyStimulus(0, 480, 0, 0, 0, 0);
    applyStimulus(1, 480, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("tick after boundary", 32'(frame_tick), 32'd1);
    checkOutput("ready after boundary", 32'(posIf.pos_ready), 32'd1);
    @(negedge clk);
    checkOutput("tick single pulse", 32'(frame_tick), 32'd0);
    applyStimulus(460, 200, 0, 0, 0, 0);
    settle(2);
    checkPixel("moved top-left", 8'he0, 10'd343, 1'b1);

    // Skirt tile flips once the 15th boundary since reset toggles the frame.
    applyStimulus(360, 460, 0, 0, 0, 0);
    settle(2);
    checkPixel("skirt frame0", 8'he0, 10'd754, 1'b1);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(0, 480, 0, 0, 0, 0);
      applyStimulus(1, 480, 0, 0, 0, 0);
    end
    applyStimulus(360, 460, 0, 0, 0, 0);
    settle(2);
    checkPixel("skirt after 14", 8'he0, 10'd754, 1'b1);
    applyStimulus(0, 480, 0, 0, 0, 0);
    applyStimulus(1, 480, 0, 0, 0, 0);
    applyStimulus(360, 460, 0, 0, 0, 0);
    settle(2);
    checkPixel("skirt frame1", 8'h03, 10'd754, 1'b1);

    // Reset mid-frame with a pending request.
    applyStimulus(260, 160, 0, 0, 0, 0);
    applyStimulus(700, 100, 1, 5, 7, 0);
    applyStimulus(700, 100, 0, 0, 0, 1);
    settle(1);
    checkPixel("mid-frame reset", 8'h00, 10'd0, 1'b0);
    checkOutput("reset ready low", 32'(posIf.pos_ready), 32'd0);
    applyStimulus(700, 100, 0, 0, 0, 1);
    applyStimulus(700, 100, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("ready after reset", 32'(posIf.pos_ready), 32'd1);
    applyStimulus(0, 480, 0, 0, 0, 0);
    applyStimulus(260, 160, 0, 0, 0, 0);
    settle(2);
    checkPixel("home after reset", 8'hff, 10'd269, 1'b1);

    applyStimulus(700, 100, 0, 0, 0, 0);
    settle(1);
    checkEn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
